// File: rtl/interrupt_controller_nested.sv
// Nested-priority interrupt controller on a 2-address 65C02-style bus; bus strobes captured on negedge, applied next posedge.
// int_in -> int_out latency two rising edges; no backpressure (a bus access always completes in one cycle).
module interrupt_controller_nested #(
    parameter int N_SOURCES = 32,
    parameter int PRIO_W    = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 rwb,
    input  logic                 addr,
    input  logic [7:0]           i_data,
    output logic [7:0]           o_data,
    input  logic [N_SOURCES-1:0] int_in,
    output logic                 int_out
);
    localparam int IDX_W = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1;
    localparam int NLVL  = 1 << PRIO_W;

    logic                 stb_wr_q, stb_rd_q, stb_addr_q;
    logic [7:0]           stb_dat_q;
    logic [7:0]           cmd_q, cmd_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_SOURCES-1:0] en_q, en_d, edg_q, edg_d, pend_q, pend_d, prev_q;
    logic [PRIO_W-1:0]    prio_q [N_SOURCES];
    logic [PRIO_W-1:0]    prio_d [N_SOURCES];
    logic [NLVL-1:0]      isr_q, isr_d;
    logic                 int_out_q;

    logic [PRIO_W-1:0]    top_isr, win_prio;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_found;
    logic [N_SOURCES-1:0] eligible, rise;
    logic [7:0]           vector, status;
    logic                 wr0, wr1, iack;

    // One-shot bus strobe: each falling edge overwrites it, so it lasts exactly one rising edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stb_wr_q   <= 1'b0;
            stb_rd_q   <= 1'b0;
            stb_addr_q <= 1'b0;
            stb_dat_q  <= '0;
        end else begin
            stb_wr_q   <= cs & ~rwb;
            stb_rd_q   <= cs & rwb;
            stb_addr_q <= addr;
            stb_dat_q  <= i_data;
        end
    end

    always_comb begin
        top_isr = '0;
        for (int l = 0; l < NLVL; l++) begin
            if (isr_q[l]) top_isr = PRIO_W'(l);
        end
    end

    // Ascending scan with strict '>' keeps the lowest index on a priority tie.
    always_comb begin
        eligible  = '0;
        win_found = 1'b0;
        win_idx   = '0;
        win_prio  = '0;
        for (int i = 0; i < N_SOURCES; i++) begin
            eligible[i] = pend_q[i] & en_q[i] & ((isr_q == '0) | (prio_q[i] > top_isr));
            if (eligible[i] && (!win_found || prio_q[i] > win_prio)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_prio  = prio_q[i];
            end
        end
    end

    assign vector  = win_found ? 8'(win_idx) : 8'hFF;
    assign status  = {int_out_q, |isr_q, 3'b000, 3'(top_isr)};
    assign o_data  = addr ? vector : status;
    assign int_out = int_out_q;

    assign wr0  = stb_wr_q & ~stb_addr_q;
    assign wr1  = stb_wr_q & stb_addr_q;
    assign iack = stb_rd_q & stb_addr_q & win_found;
    assign rise = int_in & ~prev_q;

    always_comb begin
        cmd_d  = cmd_q;
        idx_d  = idx_q;
        en_d   = en_q;
        edg_d  = edg_q;
        prio_d = prio_q;
        isr_d  = isr_q;
        pend_d = pend_q;
        if (wr0) cmd_d = stb_dat_q;
        if (wr1) begin
            case (cmd_q)
                8'h00: if ({24'd0, stb_dat_q} < 32'(N_SOURCES)) idx_d = stb_dat_q[IDX_W-1:0];
                8'h10: en_d[idx_q]   = stb_dat_q[0];
                8'h20: edg_d[idx_q]  = stb_dat_q[0];
                8'h30: prio_d[idx_q] = stb_dat_q[PRIO_W-1:0];
                8'hFF: if (isr_q != '0) isr_d[top_isr] = 1'b0;
                default: ;
            endcase
        end
        if (iack) isr_d[prio_q[win_idx]] = 1'b1;
        // A rising edge arriving in the acknowledge cycle re-arms the edge source.
        for (int i = 0; i < N_SOURCES; i++) begin
            if (edg_q[i])
                pend_d[i] = (iack && win_idx == IDX_W'(i)) ? rise[i] : (pend_q[i] | rise[i]);
            else
                pend_d[i] = int_in[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q     <= '0;
            idx_q     <= '0;
            en_q      <= '0;
            edg_q     <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            isr_q     <= '0;
            int_out_q <= 1'b0;
            for (int i = 0; i < N_SOURCES; i++) prio_q[i] <= '0;
        end else begin
            cmd_q     <= cmd_d;
            idx_q     <= idx_d;
            en_q      <= en_d;
            edg_q     <= edg_d;
            pend_q    <= pend_d;
            prev_q    <= int_in;
            isr_q     <= isr_d;
            int_out_q <= |eligible;
            prio_q    <= prio_d;
        end
    end
endmodule

// File: tb/tb_interrupt_controller_nested.sv
// Directed bench for interrupt_controller_nested: hand-computed vectors, immediate assertions.
module tb_interrupt_controller_nested;
    logic        clk = 1'b0;
    logic        reset, cs, rwb, addr;
    logic [7:0]  i_data, o_data;
    logic [31:0] int_in;
    logic        int_out;
    logic [7:0]  v;
    int          ntests = 0;
    int          nfail  = 0;

    always #5 clk = ~clk;

    interrupt_controller_nested #(.N_SOURCES(32), .PRIO_W(3)) dut (
        .clk(clk), .reset(reset), .cs(cs), .rwb(rwb), .addr(addr),
        .i_data(i_data), .o_data(o_data), .int_in(int_in), .int_out(int_out)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, {7'd0, int_out}, {7'd0, exp});
    endtask

    // All bus tasks start and end 1ns after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
        @(negedge clk); #1 cs = 1'b0; rwb = 1'b1;
        tick(1);
    endtask

    task automatic rd(input logic a, output logic [7:0] d);
        cs = 1'b1; rwb = 1'b1; addr = a;
        #1 d = o_data;
        @(negedge clk); #1 cs = 1'b0;
        tick(1);
    endtask

    task automatic cfg(input logic [7:0] src, input logic en, input logic edg, input logic [7:0] pr);
        wr(1'b0, 8'h00); wr(1'b1, src);
        wr(1'b0, 8'h10); wr(1'b1, {7'd0, en});
        wr(1'b0, 8'h20); wr(1'b1, {7'd0, edg});
        wr(1'b0, 8'h30); wr(1'b1, pr);
    endtask

    task automatic eoi();
        wr(1'b0, 8'hFF); wr(1'b1, 8'h00);
    endtask

    task automatic pulse(input int src);
        int_in[src] = 1'b1;
        tick(1);
        int_in[src] = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rwb = 1'b1; addr = 1'b1; i_data = '0; int_in = '0;
        #1;
        check_irq("rst_irq", 1'b0);
        check("rst_vec_comb", o_data, 8'hFF);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick(1);
        rd(1'b0, v); check("rst_status", v, 8'h00);
        rd(1'b1, v); check("rst_iack", v, 8'hFF);

        // Single edge source
        cfg(8'd0, 1'b1, 1'b1, 8'd2);
        int_in[0] = 1'b1;
        tick(1);
        int_in[0] = 1'b0;
        check_irq("lat_edge1", 1'b0);
        tick(1);
        check_irq("lat_edge2", 1'b1);
        rd(1'b1, v); check("iack_src0", v, 8'h00);
        rd(1'b0, v); check("status_c2", v, 8'hC2);
        check_irq("irq_drop", 1'b0);
        eoi();
        rd(1'b0, v); check("eoi_status", v, 8'h00);

        // Nesting
        cfg(8'd5, 1'b1, 1'b1, 8'd5);
        pulse(0); tick(1);
        rd(1'b1, v); check("nest_iack0", v, 8'h00);
        pulse(5); tick(1);
        check_irq("nest_irq", 1'b1);
        rd(1'b1, v); check("nest_iack5", v, 8'h05);
        rd(1'b0, v); check("nest_status", v, 8'hC5);
        eoi();
        rd(1'b0, v); check("nest_eoi1", v, 8'h42);
        wr(1'b1, 8'h00);
        rd(1'b0, v); check("nest_eoi2", v, 8'h00);

        // Tie-break and equal-priority hold-off
        cfg(8'd3, 1'b1, 1'b1, 8'd4);
        cfg(8'd7, 1'b1, 1'b1, 8'd4);
        int_in[3] = 1'b1; int_in[7] = 1'b1;
        tick(1);
        int_in[3] = 1'b0; int_in[7] = 1'b0;
        tick(1);
        check_irq("tie_irq", 1'b1);
        rd(1'b1, v); check("tie_iack", v, 8'h03);
        tick(1);
        check_irq("same_lvl_held", 1'b0);
        rd(1'b1, v); check("same_lvl_vec", v, 8'hFF);
        eoi();
        rd(1'b1, v); check("tie_second", v, 8'h07);
        wr(1'b1, 8'h00);

        // Raise src7 above src3 before acknowledging
        int_in[3] = 1'b1; int_in[7] = 1'b1;
        tick(1);
        int_in[3] = 1'b0; int_in[7] = 1'b0;
        tick(1);
        wr(1'b0, 8'h00); wr(1'b1, 8'd7);
        wr(1'b0, 8'h30); wr(1'b1, 8'd6);
        rd(1'b1, v); check("prio_raise", v, 8'h07);
        rd(1'b0, v); check("prio_status", v, 8'hC6);
        eoi();
        rd(1'b1, v); check("prio_then3", v, 8'h03);
        wr(1'b1, 8'h00);

        // Level mode
        cfg(8'd1, 1'b1, 1'b0, 8'd1);
        int_in[1] = 1'b1;
        tick(2);
        check_irq("lvl_irq", 1'b1);
        rd(1'b1, v); check("lvl_iack", v, 8'h01);
        tick(2);
        check_irq("lvl_in_service", 1'b0);
        rd(1'b1, v); check("lvl_vec_held", v, 8'hFF);
        eoi();
        tick(1);
        check_irq("lvl_reassert", 1'b1);
        int_in[1] = 1'b0;
        tick(1);
        check_irq("lvl_drop_e1", 1'b1);
        tick(1);
        check_irq("lvl_drop_e2", 1'b0);

        // Masking
        cfg(8'd9, 1'b0, 1'b1, 8'd3);
        pulse(9); tick(2);
        check_irq("mask_irq", 1'b0);
        rd(1'b1, v); check("mask_vec", v, 8'hFF);
        wr(1'b0, 8'h10); wr(1'b1, 8'h01);
        tick(1);
        check_irq("unmask_irq", 1'b1);
        rd(1'b1, v); check("unmask_iack", v, 8'h09);

        // Reset between falling and rising edge of a command write
        cs = 1'b1; rwb = 1'b0; addr = 1'b0; i_data = 8'h10;
        @(negedge clk);
        #1 cs = 1'b0; rwb = 1'b1; reset = 1'b1; addr = 1'b1;
        #1;
        check_irq("midrst_irq", 1'b0);
        check("midrst_vec", o_data, 8'hFF);
        reset = 1'b0;
        tick(1);
        wr(1'b1, 8'h01);
        int_in[0] = 1'b1;
        tick(2);
        check_irq("midrst_en0", 1'b0);
        rd(1'b1, v); check("midrst_iack", v, 8'hFF);
        int_in[0] = 1'b0;
        rd(1'b0, v); check("midrst_status", v, 8'h00);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
